npc_hazard_unit: RTL
====================

Name: npc_hazard_unit

Overview:
- Parametrised hazard-detection and forwarding unit for the npc in-order pipeline; sits beside the ID stage.
- Shifts a record of every in-flight destination register through NUM_STAGES post-ID slots (slot 0 = EX, ascending toward WB).
- For each source operand decoded in ID, selects forwarded data from the youngest matching slot, or raises a load-use stall.
- Replaces fixed EX/MEM comparators with a depth- and width-generic scoreboard, and adds a stall-cycle performance counter.

Parameters:
- NUM_STAGES, 3, number of post-ID slots tracked (EX, MEM, WB), range 2..8
- XLEN, 64, data width
- LOAD_STAGE, 1, first slot index at which load data is valid on stage_result (1 = MEM output), must be < NUM_STAGES
- CNT_W, 32, width of the stall counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- id_valid  input  1  ID holds a real instruction
- id_rs1, id_rs2  input  5 each  source register addresses
- id_rs1_use, id_rs2_use  input  1 each  operand actually read
- id_rd  input  5  destination register
- id_we  input  1  instruction writes rd
- id_load  input  1  instruction is a load
- flush  input  1  branch redirect: squash the ID instruction
- rf_rdata1, rf_rdata2  input  XLEN each  register-file read data
- stage_result  input  NUM_STAGES*XLEN  result bus per slot; slot i occupies bits [i*XLEN +: XLEN]
- stall  output  1  hold PC and IF/ID; EX receives a bubble
- fwd_data1, fwd_data2  output  XLEN each  operand values for ID
- fwd_hit1, fwd_hit2  output  1 each  operand taken from a slot rather than rf_rdata
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Slot record: {v, rd, ld}.
  - v is set only when the instruction writes and rd != 0.
  - Record storage resets asynchronously: all v = 0, rd = 0, ld = 0. stall_cnt resets to 0.
- Every rising edge, slot[i] <= slot[i-1] for i >= 1. The pipeline past ID never stalls.
- slot[0] update on each edge:
  - If id_valid & ~stall & ~flush: slot[0] <= {id_we & (id_rd != 0), id_rd, id_load}.
  - Otherwise slot[0] <= bubble (v = 0).
- Lookup per operand k (combinational, same cycle):
  - A match is slot i with v = 1 and rd == id_rsk, where id_rsk != 0.
  - The winner is the lowest matching i (youngest writer).
  - If there is no match, or the operand is x0: fwd_hitk = 0 and fwd_datak = rf_rdatak.
  - If the winner has ld = 1 and i < LOAD_STAGE: the operand is in load-use hazard. fwd_hitk = 0 and fwd_datak = rf_rdatak; the value is don't-care while stalled.
  - Otherwise: fwd_hitk = 1 and fwd_datak = stage_result[winner].
- stall = id_valid & ~flush & ((id_rs1_use & hazard1) | (id_rs2_use & hazard2)).
  - flush has priority over stall, so the redirect is never blocked.
- Zero-latency rule: outputs depend only on current inputs and registered slots.
  - A stalled instruction re-evaluates the next cycle against the advanced slots.
  - It resolves after (LOAD_STAGE - i) stall cycles.
- Slot NUM_STAGES-1 is the writeback slot.
  - It is forwarded because the register file is written on the same edge and a read in the same cycle would return stale data.
- stall_cnt increments by 1 on each edge with stall = 1, and saturates at all-ones.
- Reset asserted mid-stall: stall deasserts immediately (slots cleared asynchronously), and stall_cnt returns to 0.
- Unused operand (use = 0) never causes a stall, even on a match. fwd_data is still produced.
- Non-writing instructions (id_we = 0) and rd = x0 never occupy a slot.

Test Plan:
- Back-to-back ALU dependency: `addi x5,x0,7` then `add x6,x5,x5` with stage_result slot0 = 7 → fwd_hit1 = fwd_hit2 = 1, fwd_data1 = fwd_data2 = 7, stall = 0.
- Load-use (defaults): `ld x5` followed by `add x6,x5,x1`:
  - Cycle 1: stall = 1 and a bubble is inserted.
  - Next cycle: slot1 match, fwd_data1 = stage_result slot1 = 0xDEAD, stall = 0.
  - stall_cnt = 1.
- Youngest-wins: writes to x3 in slots 2, 1 and 0 carrying 0x11, 0x22, 0x33 → fwd_data for x3 = 0x33.
- x0 and no-write:
  - `addi x0,...` then read of x0 → fwd_hit = 0, data = rf_rdata.
  - A store with id_we = 0 followed by a read of the same rd → fwd_hit = 0.
- Flush during hazard: load-use condition with flush = 1 → stall = 0, and slot0 becomes a bubble on the next edge.
- Reset mid-stall and saturation:
  - Assert rst asynchronously during a stall → stall = 0 and stall_cnt = 0 before the next edge.
  - With CNT_W = 4 and 20 forced stall cycles → stall_cnt = 15.

Source files
------------

// File: rtl/npc_hazard_unit.sv
// Hazard detection and operand forwarding for the npc in-order pipeline.
// Tracks in-flight destination registers across NUM_STAGES post-ID slots (slot 0 = EX).
module npc_hazard_unit #(
    parameter int NUM_STAGES = 3,
    parameter int XLEN       = 64,
    parameter int LOAD_STAGE = 1,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [4:0]                 id_rs1,
    input  logic [4:0]                 id_rs2,
    input  logic                       id_rs1_use,
    input  logic                       id_rs2_use,
    input  logic [4:0]                 id_rd,
    input  logic                       id_we,
    input  logic                       id_load,
    input  logic                       flush,
    input  logic [XLEN-1:0]            rf_rdata1,
    input  logic [XLEN-1:0]            rf_rdata2,
    input  logic [NUM_STAGES*XLEN-1:0] stage_result,
    output logic                       stall,
    output logic [XLEN-1:0]            fwd_data1,
    output logic [XLEN-1:0]            fwd_data2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [CNT_W-1:0]           stall_cnt
);

    typedef struct packed {
        logic            hit;
        logic            hazard;
        logic [XLEN-1:0] data;
    } lookup_t;

    logic [NUM_STAGES-1:0]      slot_v;
    logic [NUM_STAGES-1:0]      slot_ld;
    logic [NUM_STAGES-1:0][4:0] slot_rd;

    lookup_t op1;
    lookup_t op2;
    logic    issue;

    // Scan oldest to youngest so the lowest matching slot overrides the rest.
    function automatic lookup_t lookup(
        input logic [4:0]                 rs,
        input logic [XLEN-1:0]            rf_data,
        input logic [NUM_STAGES-1:0]      v,
        input logic [NUM_STAGES-1:0][4:0] rd,
        input logic [NUM_STAGES-1:0]      ld,
        input logic [NUM_STAGES*XLEN-1:0] results
    );
        lookup_t r;
        r.hit    = 1'b0;
        r.hazard = 1'b0;
        r.data   = rf_data;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (rs != 5'd0 && v[i] && rd[i] == rs) begin
                if (ld[i] && i < LOAD_STAGE) begin
                    r.hit    = 1'b0;
                    r.hazard = 1'b1;
                    r.data   = rf_data;
                end else begin
                    r.hit    = 1'b1;
                    r.hazard = 1'b0;
                    r.data   = results[i*XLEN +: XLEN];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        op1 = lookup(id_rs1, rf_rdata1, slot_v, slot_rd, slot_ld, stage_result);
        op2 = lookup(id_rs2, rf_rdata2, slot_v, slot_rd, slot_ld, stage_result);
    end

    assign stall     = id_valid & ~flush &
                       ((id_rs1_use & op1.hazard) | (id_rs2_use & op2.hazard));
    assign fwd_hit1  = op1.hit;
    assign fwd_hit2  = op2.hit;
    assign fwd_data1 = op1.data;
    assign fwd_data2 = op2.data;
    assign issue     = id_valid & ~stall & ~flush;

    // Records advance every edge; a stalled or flushed ID instruction becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v  <= '0;
            slot_ld <= '0;
            slot_rd <= '0;
        end else begin
            slot_v  <= {slot_v[NUM_STAGES-2:0], issue & id_we & (id_rd != 5'd0)};
            slot_ld <= {slot_ld[NUM_STAGES-2:0], issue & id_load};
            slot_rd <= {slot_rd[NUM_STAGES-2:0], issue ? id_rd : 5'd0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
